// File: rtl/cdc_fifo_gray_pkg.sv
// Shared sizing helpers for the gray-pointer async FIFO halves.
// Both halves derive their pointer and fill widths from LOG_DEPTH here.
package cdc_fifo_gray_pkg;

  function automatic int ptr_width(input int log_depth);
    return log_depth + 1;
  endfunction

  function automatic int fill_width(input int log_depth);
    return log_depth + 2;
  endfunction

endpackage

// File: rtl/cdc_gray_ptr_sync.sv
// Multi-flop synchronizer for a gray-coded pointer, followed by gray-to-binary.
// The pointer is only safe to sample because successive values differ in one bit.
module cdc_gray_ptr_sync #(
  parameter int PTR_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [PTR_W-1:0] i_grayAsync,
  output logic [PTR_W-1:0] o_bin
);

  logic [PTR_W-1:0] r_sync [SYNC_STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= i_grayAsync;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  // Binary bit b is the XOR of all gray bits at and above b.
  always_comb begin
    o_bin = '0;
    for (int b = 0; b < PTR_W; b++) begin
      o_bin[b] = ^(r_sync[SYNC_STAGES-1] >> b);
    end
  end

endmodule

// File: rtl/cdc_fifo_gray_dst_fill.sv
// Destination half of the gray-pointer async FIFO: pops source memory into a
// 2-entry spill stage and reports a registered fill level plus almost-empty.
module cdc_fifo_gray_dst_fill
  import cdc_fifo_gray_pkg::*;
#(
  parameter int  WIDTH       = 1,
  parameter type T           = logic [WIDTH-1:0],
  parameter int  LOG_DEPTH   = 3,
  parameter int  SYNC_STAGES = 2,
  parameter int  AE_THRESH   = 1
) (
  input  logic                                dst_clk_i,
  input  logic                                dst_rst_ni,
  output T                                    dst_data_o,
  output logic                                dst_valid_o,
  input  logic                                dst_ready_i,
  output logic [fill_width(LOG_DEPTH)-1:0]    dst_fill_o,
  output logic                                dst_almost_empty_o,
  input  T                                    async_data_i [2**LOG_DEPTH],
  input  logic [ptr_width(LOG_DEPTH)-1:0]     async_wptr_i,
  output logic [ptr_width(LOG_DEPTH)-1:0]     async_rptr_o
);

  localparam int PTR_W  = ptr_width(LOG_DEPTH);
  localparam int FILL_W = fill_width(LOG_DEPTH);
  localparam int DEPTH  = 2**LOG_DEPTH;
  localparam logic [FILL_W-1:0] AE_LIMIT = FILL_W'(AE_THRESH);

  if (LOG_DEPTH < 1 || SYNC_STAGES < 2) begin : g_badParams
    $error("cdc_fifo_gray_dst_fill: LOG_DEPTH must be >= 1 and SYNC_STAGES >= 2");
  end

  logic [PTR_W-1:0]  w_wptrBin;
  logic [PTR_W-1:0]  w_memCnt;
  logic [PTR_W-1:0]  w_memCntNext;
  logic [PTR_W-1:0]  w_rptrBinNext;
  logic [PTR_W-1:0]  r_rptrBin;
  logic [PTR_W-1:0]  r_rptrGray;
  logic              w_memValid;
  logic              w_stageReady;
  logic              w_pop;
  T                  w_memData;

  T                  r_aData;
  T                  r_bData;
  logic              r_aFull;
  logic              r_bFull;
  logic              w_aFill;
  logic              w_aDrain;
  logic              w_bFill;
  logic              w_bDrain;
  logic              w_aFullNext;
  logic              w_bFullNext;

  logic [FILL_W-1:0] r_fill;
  logic [FILL_W-1:0] w_fillNext;

  cdc_gray_ptr_sync #(
    .PTR_W       (PTR_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_wptrSync (
    .i_clk       (dst_clk_i),
    .i_rst_n     (dst_rst_ni),
    .i_grayAsync (async_wptr_i),
    .o_bin       (w_wptrBin)
  );

  assign w_memCnt      = w_wptrBin - r_rptrBin;
  assign w_memValid    = (w_memCnt != '0);
  assign w_memData     = async_data_i[r_rptrBin[LOG_DEPTH-1:0]];
  assign w_stageReady  = !r_aFull || !r_bFull;
  assign w_pop         = w_memValid && w_stageReady;
  assign w_rptrBinNext = r_rptrBin + PTR_W'(w_pop);

  always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
    if (!dst_rst_ni) begin
      r_rptrBin  <= '0;
      r_rptrGray <= '0;
    end else if (w_pop) begin
      r_rptrBin  <= w_rptrBinNext;
      r_rptrGray <= w_rptrBinNext ^ (w_rptrBinNext >> 1);
    end
  end

  // Slot A takes new entries; B only holds A's entry when the consumer stalls.
  assign w_aFill     = w_pop;
  assign w_aDrain    = r_aFull && !r_bFull;
  assign w_bFill     = w_aDrain && !dst_ready_i;
  assign w_bDrain    = r_bFull && dst_ready_i;
  assign w_aFullNext = w_aFill || (r_aFull && !w_aDrain);
  assign w_bFullNext = w_bFill || (r_bFull && !w_bDrain);

  always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
    if (!dst_rst_ni) begin
      r_aData <= '0;
      r_bData <= '0;
      r_aFull <= 1'b0;
      r_bFull <= 1'b0;
    end else begin
      if (w_aFill) begin
        r_aData <= w_memData;
      end
      if (w_bFill) begin
        r_bData <= r_aData;
      end
      r_aFull <= w_aFullNext;
      r_bFull <= w_bFullNext;
    end
  end

  // Memory term uses this cycle's synced write pointer, so a write shows up
  // in the fill level on the same edge as the head becomes valid.
  assign w_memCntNext = w_wptrBin - w_rptrBinNext;
  assign w_fillNext   = FILL_W'(w_memCntNext) + FILL_W'(w_aFullNext) + FILL_W'(w_bFullNext);

  always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
    if (!dst_rst_ni) begin
      r_fill <= '0;
    end else begin
      r_fill <= w_fillNext;
    end
  end

  assign dst_valid_o        = r_aFull || r_bFull;
  assign dst_data_o         = r_bFull ? r_bData : r_aData;
  assign dst_fill_o         = r_fill;
  assign dst_almost_empty_o = (r_fill <= AE_LIMIT);
  assign async_rptr_o       = r_rptrGray;

  a_memCntRange: assert property (@(posedge dst_clk_i) disable iff (!dst_rst_ni)
    w_memCnt <= PTR_W'(DEPTH));

  a_dataStable: assert property (@(posedge dst_clk_i) disable iff (!dst_rst_ni)
    (dst_valid_o && !dst_ready_i) |=> $stable(dst_data_o));

  a_wptrOneBit: assert property (@(posedge dst_clk_i) disable iff (!dst_rst_ni)
    $countones(async_wptr_i ^ $past(async_wptr_i)) <= 1);

endmodule

// File: tb/tb_cdc_fifo_gray_dst_fill.sv
// Bench for cdc_fifo_gray_dst_fill: a source-side model writes memory and gray
// pointers, and a queue scoreboard predicts data, fill, valid and almost-empty.
module tb_cdc_fifo_gray_dst_fill;

  localparam int SYNC = 2;
  localparam int AE   = 2;

  logic       clk = 1'b0;
  logic       rstN;
  logic [7:0] dstData;
  logic       dstValid;
  logic       dstReady;
  logic [4:0] dstFill;
  logic       dstAe;
  logic [7:0] srcMem [8];
  logic [3:0] asyncWptr;
  logic [3:0] asyncRptr;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] expQ [$];
  int         wHist [$];
  int         wcnt;
  int         consumed;
  int         edgeCnt = 0;
  int         firstHs;
  int         lastHs;
  int         wraps;
  logic [3:0] prevRptr;

  cdc_fifo_gray_dst_fill #(
    .WIDTH       (8),
    .LOG_DEPTH   (3),
    .SYNC_STAGES (SYNC),
    .AE_THRESH   (AE)
  ) dut (
    .dst_clk_i          (clk),
    .dst_rst_ni         (rstN),
    .dst_data_o         (dstData),
    .dst_valid_o        (dstValid),
    .dst_ready_i        (dstReady),
    .dst_fill_o         (dstFill),
    .dst_almost_empty_o (dstAe),
    .async_data_i       (srcMem),
    .async_wptr_i       (asyncWptr),
    .async_rptr_o       (asyncRptr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [3:0] bin2gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Entries become visible SYNC+1 edges after the pointer change; consumes count at once.
  task automatic checkModel();
    int vis;
    int expFill;
    vis = (wHist.size() > SYNC) ? wHist[wHist.size()-1-SYNC] : 0;
    expFill = vis - consumed;
    checkOutput("fill", dstFill, expFill);
    checkOutput("valid", dstValid, expFill != 0);
    checkOutput("almostEmpty", dstAe, expFill <= AE);
    if (expFill != 0 && expQ.size() > 0) checkOutput("data", dstData, expQ[0]);
  endtask

  task automatic applyStimulus(input bit doWrite, input bit ready, input logic [7:0] value);
    int occ;
    bit hs;
    dstReady = ready;
    if (doWrite) begin
      occ = (wcnt - int'(gray2bin(asyncRptr))) & 15;
      if (occ < 8) begin
        srcMem[wcnt % 8] = value;
        expQ.push_back(value);
        wcnt++;
        asyncWptr = bin2gray(4'(wcnt));
      end
    end
    @(negedge clk);
    hs = dstValid && dstReady;
    @(posedge clk);
    edgeCnt++;
    wHist.push_back(wcnt);
    if (wHist.size() > 8) void'(wHist.pop_front());
    if (hs) begin
      void'(expQ.pop_front());
      consumed++;
      lastHs = edgeCnt;
      if (firstHs < 0) firstHs = edgeCnt;
    end
    #1;
    if (prevRptr == 4'b1000 && asyncRptr == 4'b0000) wraps++;
    prevRptr = asyncRptr;
    checkModel();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, dstValid, 0);
    checkOutput({tag, "_fill"}, dstFill, 0);
    checkOutput({tag, "_rptr"}, asyncRptr, 0);
    checkOutput({tag, "_ae"}, dstAe, 1);
    checkOutput({tag, "_data"}, dstData, 0);
  endtask

  task automatic applyReset();
    rstN = 1'b0;
    asyncWptr = '0;
    dstReady = 1'b0;
    expQ.delete();
    wHist.delete();
    wcnt = 0;
    consumed = 0;
    firstHs = -1;
    lastHs = -1;
    wraps = 0;
    prevRptr = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("rst");
    rstN = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && expQ.size() > 0; i++) applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("drained", dstFill, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) srcMem[i] = '0;
    $display("[TB] start");

    // Reset and idle hold.
    applyReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    checkResetOutputs("t1_hold");

    // Single entry latency and consume.
    applyStimulus(1'b1, 1'b0, 8'hA5);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("t2_notYet", dstValid, 0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("t2_valid", dstValid, 1);
    checkOutput("t2_fill", dstFill, 1);
    checkOutput("t2_data", dstData, 8'hA5);
    checkOutput("t2_rptr", asyncRptr, 4'h1);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("t2_consumed", dstFill, 0);

    // Backpressure with 8 entries.
    applyReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("t3_fill", dstFill, 8);
    checkOutput("t3_rptr", asyncRptr, 4'h3);
    checkOutput("t3_head", dstData, 8'h10);
    drain();

    // Streaming 40 entries with wrap.
    applyReset();
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1, 8'(i));
    drain();
    checkOutput("t4_count", consumed, 40);
    checkOutput("t4_gapless", lastHs - firstHs, 39);
    checkOutput("t4_wraps", wraps, 2);
    checkOutput("t4_rptr", asyncRptr, 4'hC);

    // Almost-empty threshold while draining.
    applyReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("t5_fill4", dstFill, 4);
    checkOutput("t5_ae4", dstAe, 0);
    for (int j = 1; j <= 4; j++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput("t5_fillStep", dstFill, 4 - j);
      checkOutput("t5_aeStep", dstAe, j >= 2);
    end

    // Asynchronous reset mid-stream.
    applyReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'(8'h60 + i));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("t6_fill5", dstFill, 5);
    rstN = 1'b0;
    asyncWptr = '0;
    #1;
    checkResetOutputs("t6_async");
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'(8'h70 + i));
    drain();
    checkOutput("t6_rptr", asyncRptr, bin2gray(4'd3));

    // Randomized traffic: slow consumer first (reaches full), then fast.
    applyReset();
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) < 55,
                    $urandom_range(0, 99) < ((i < 300) ? 25 : 80),
                    8'($urandom));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
